// File: rtl/maxigp_port_splitter.sv
// maxigp_port_splitter
//
// Routes the PS7 MAXIGP0 AXI GP master channels to NPORT user slave ports.
// A 4-bit field of the address, addr[SEL_LSB+3:SEL_LSB], selects the port.
// Read and write directions are handled by two independent FSMs, and each
// direction has at most one transaction in flight. An address that selects
// a port number >= NPORT is answered locally with DECERR (resp = 2'b11).
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   MAXIGP0_O_AR / _AW        upstream read/write address (addr, id, len)
//   MAXIGP0_O_W               upstream write data (data, id ignored, last)
//   MAXIGP0_I_R               upstream read data (data, id, last, resp)
//   MAXIGP0_I_B               upstream write response (id, resp)
//   port_AR / port_AW         per-port address handshakes (addr, len), packed by port
//   port_W                    per-port write data (data, last)
//   port_R                    per-port read data (data, last, resp)
//   port_B                    per-port write response (resp)
// Packed per-port vectors carry port n at [n*W +: W].
module maxigp_port_splitter #(
   parameter int NPORT      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 12,
   parameter int SEL_LSB    = 12
) (
   input  logic                        CLK,
   input  logic                        nRST,

   input  logic                        MAXIGP0_O_AR__ENA,
   output logic                        MAXIGP0_O_AR__RDY,
   input  logic [31:0]                 MAXIGP0_O_AR_addr,
   input  logic [ID_WIDTH-1:0]         MAXIGP0_O_AR_id,
   input  logic [3:0]                  MAXIGP0_O_AR_len,

   input  logic                        MAXIGP0_O_AW__ENA,
   output logic                        MAXIGP0_O_AW__RDY,
   input  logic [31:0]                 MAXIGP0_O_AW_addr,
   input  logic [ID_WIDTH-1:0]         MAXIGP0_O_AW_id,
   input  logic [3:0]                  MAXIGP0_O_AW_len,

   input  logic                        MAXIGP0_O_W__ENA,
   output logic                        MAXIGP0_O_W__RDY,
   input  logic [DATA_WIDTH-1:0]       MAXIGP0_O_W_data,
   input  logic [ID_WIDTH-1:0]         MAXIGP0_O_W_id,
   input  logic                        MAXIGP0_O_W_last,

   output logic                        MAXIGP0_I_R__ENA,
   input  logic                        MAXIGP0_I_R__RDY,
   output logic [DATA_WIDTH-1:0]       MAXIGP0_I_R_data,
   output logic [ID_WIDTH-1:0]         MAXIGP0_I_R_id,
   output logic                        MAXIGP0_I_R_last,
   output logic [1:0]                  MAXIGP0_I_R_resp,

   output logic                        MAXIGP0_I_B__ENA,
   input  logic                        MAXIGP0_I_B__RDY,
   output logic [ID_WIDTH-1:0]         MAXIGP0_I_B_id,
   output logic [1:0]                  MAXIGP0_I_B_resp,

   output logic [NPORT-1:0]            port_AR__ENA,
   input  logic [NPORT-1:0]            port_AR__RDY,
   output logic [32*NPORT-1:0]         port_AR_addr,
   output logic [4*NPORT-1:0]          port_AR_len,

   output logic [NPORT-1:0]            port_AW__ENA,
   input  logic [NPORT-1:0]            port_AW__RDY,
   output logic [32*NPORT-1:0]         port_AW_addr,
   output logic [4*NPORT-1:0]          port_AW_len,

   output logic [NPORT-1:0]            port_W__ENA,
   input  logic [NPORT-1:0]            port_W__RDY,
   output logic [DATA_WIDTH*NPORT-1:0] port_W_data,
   output logic [NPORT-1:0]            port_W_last,

   input  logic [NPORT-1:0]            port_R__ENA,
   output logic [NPORT-1:0]            port_R__RDY,
   input  logic [DATA_WIDTH*NPORT-1:0] port_R_data,
   input  logic [NPORT-1:0]            port_R_last,
   input  logic [2*NPORT-1:0]          port_R_resp,

   input  logic [NPORT-1:0]            port_B__ENA,
   output logic [NPORT-1:0]            port_B__RDY,
   input  logic [2*NPORT-1:0]          port_B_resp
);

   typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DATA, RD_ERR} rd_state_t;
   typedef enum logic [2:0] {WR_IDLE, WR_ISSUE, WR_DATA, WR_RESP, WR_DRAIN, WR_ERR} wr_state_t;

   localparam logic [4:0] NPORT_W = 5'(NPORT);

   rd_state_t             rd_state, rd_next;
   wr_state_t             wr_state, wr_next;
   logic                  ready_en;
   logic [31:0]           rd_addr, wr_addr;
   logic [ID_WIDTH-1:0]   rd_id, wr_id;
   logic [3:0]            rd_len, wr_len;
   logic [3:0]            rd_sel, wr_sel;
   logic [3:0]            rd_cnt;
   logic [3:0]            ar_sel, aw_sel;
   logic                  ar_hit, aw_hit, ar_fire, aw_fire, rd_err_last;
   logic                  unused_w_id;

   // The W id carries no information here; the latched AW id is used instead.
   assign unused_w_id = ^MAXIGP0_O_W_id;

   assign ar_sel      = MAXIGP0_O_AR_addr[SEL_LSB+3:SEL_LSB];
   assign aw_sel      = MAXIGP0_O_AW_addr[SEL_LSB+3:SEL_LSB];
   assign ar_hit      = ({1'b0, ar_sel} < NPORT_W);
   assign aw_hit      = ({1'b0, aw_sel} < NPORT_W);
   assign ar_fire     = MAXIGP0_O_AR__ENA && MAXIGP0_O_AR__RDY;
   assign aw_fire     = MAXIGP0_O_AW__ENA && MAXIGP0_O_AW__RDY;
   assign rd_err_last = (rd_cnt == rd_len);

   // Address/len come from registers and are broadcast; only the ENA of the
   // selected port qualifies them. W data is broadcast the same way.
   assign port_AR_addr    = {NPORT{rd_addr}};
   assign port_AR_len     = {NPORT{rd_len}};
   assign port_AW_addr    = {NPORT{wr_addr}};
   assign port_AW_len     = {NPORT{wr_len}};
   assign port_W_data     = {NPORT{MAXIGP0_O_W_data}};
   assign port_W_last     = {NPORT{MAXIGP0_O_W_last}};
   assign MAXIGP0_I_R_id  = rd_id;
   assign MAXIGP0_I_B_id  = wr_id;

   // ready_en holds AR/AW ready low until the first clock after reset release.
   // The DECERR beat counter restarts on every accepted AR.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ready_en <= 1'b0;
         rd_state <= RD_IDLE;
         rd_addr  <= '0;
         rd_id    <= '0;
         rd_len   <= '0;
         rd_sel   <= '0;
         rd_cnt   <= '0;
      end else begin
         ready_en <= 1'b1;
         rd_state <= rd_next;
         if (ar_fire) begin
            rd_addr <= MAXIGP0_O_AR_addr;
            rd_id   <= MAXIGP0_O_AR_id;
            rd_len  <= MAXIGP0_O_AR_len;
            rd_sel  <= ar_sel;
            rd_cnt  <= '0;
         end else if (rd_state == RD_ERR && MAXIGP0_I_R__RDY) begin
            rd_cnt <= rd_err_last ? 4'd0 : rd_cnt + 4'd1;
         end
      end
   end

   // Write address latch and write FSM state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_state <= WR_IDLE;
         wr_addr  <= '0;
         wr_id    <= '0;
         wr_len   <= '0;
         wr_sel   <= '0;
      end else begin
         wr_state <= wr_next;
         if (aw_fire) begin
            wr_addr <= MAXIGP0_O_AW_addr;
            wr_id   <= MAXIGP0_O_AW_id;
            wr_len  <= MAXIGP0_O_AW_len;
            wr_sel  <= aw_sel;
         end
      end
   end

   // Read FSM: issue AR to the selected port, then pass R through unchanged
   // except for the id. Misses produce len+1 zero-data DECERR beats locally.
   always_comb begin
      rd_next           = rd_state;
      MAXIGP0_O_AR__RDY = 1'b0;
      MAXIGP0_I_R__ENA  = 1'b0;
      MAXIGP0_I_R_data  = '0;
      MAXIGP0_I_R_last  = 1'b0;
      MAXIGP0_I_R_resp  = 2'b00;
      port_AR__ENA      = '0;
      port_R__RDY       = '0;
      case (rd_state)
         RD_IDLE: begin
            MAXIGP0_O_AR__RDY = ready_en;
            if (MAXIGP0_O_AR__ENA && ready_en)
               rd_next = ar_hit ? RD_ISSUE : RD_ERR;
         end
         RD_ISSUE: begin
            for (int n = 0; n < NPORT; n++) begin
               if (rd_sel == 4'(n)) begin
                  port_AR__ENA[n] = 1'b1;
                  if (port_AR__RDY[n])
                     rd_next = RD_DATA;
               end
            end
         end
         RD_DATA: begin
            for (int n = 0; n < NPORT; n++) begin
               if (rd_sel == 4'(n)) begin
                  MAXIGP0_I_R__ENA = port_R__ENA[n];
                  MAXIGP0_I_R_data = port_R_data[n*DATA_WIDTH +: DATA_WIDTH];
                  MAXIGP0_I_R_last = port_R_last[n];
                  MAXIGP0_I_R_resp = port_R_resp[n*2 +: 2];
                  port_R__RDY[n]   = MAXIGP0_I_R__RDY;
                  if (port_R__ENA[n] && MAXIGP0_I_R__RDY && port_R_last[n])
                     rd_next = RD_IDLE;
               end
            end
         end
         RD_ERR: begin
            MAXIGP0_I_R__ENA = 1'b1;
            MAXIGP0_I_R_resp = 2'b11;
            MAXIGP0_I_R_last = rd_err_last;
            if (MAXIGP0_I_R__RDY && rd_err_last)
               rd_next = RD_IDLE;
         end
         default: rd_next = RD_IDLE;
      endcase
   end

   // Write FSM: issue AW, pass W through until last, then pass B back with
   // the latched id. Misses swallow W beats up to last and answer DECERR.
   always_comb begin
      wr_next           = wr_state;
      MAXIGP0_O_AW__RDY = 1'b0;
      MAXIGP0_O_W__RDY  = 1'b0;
      MAXIGP0_I_B__ENA  = 1'b0;
      MAXIGP0_I_B_resp  = 2'b00;
      port_AW__ENA      = '0;
      port_W__ENA       = '0;
      port_B__RDY       = '0;
      case (wr_state)
         WR_IDLE: begin
            MAXIGP0_O_AW__RDY = ready_en;
            if (MAXIGP0_O_AW__ENA && ready_en)
               wr_next = aw_hit ? WR_ISSUE : WR_DRAIN;
         end
         WR_ISSUE: begin
            for (int n = 0; n < NPORT; n++) begin
               if (wr_sel == 4'(n)) begin
                  port_AW__ENA[n] = 1'b1;
                  if (port_AW__RDY[n])
                     wr_next = WR_DATA;
               end
            end
         end
         WR_DATA: begin
            for (int n = 0; n < NPORT; n++) begin
               if (wr_sel == 4'(n)) begin
                  MAXIGP0_O_W__RDY = port_W__RDY[n];
                  port_W__ENA[n]   = MAXIGP0_O_W__ENA;
                  if (MAXIGP0_O_W__ENA && port_W__RDY[n] && MAXIGP0_O_W_last)
                     wr_next = WR_RESP;
               end
            end
         end
         WR_RESP: begin
            for (int n = 0; n < NPORT; n++) begin
               if (wr_sel == 4'(n)) begin
                  MAXIGP0_I_B__ENA = port_B__ENA[n];
                  MAXIGP0_I_B_resp = port_B_resp[n*2 +: 2];
                  port_B__RDY[n]   = MAXIGP0_I_B__RDY;
                  if (port_B__ENA[n] && MAXIGP0_I_B__RDY)
                     wr_next = WR_IDLE;
               end
            end
         end
         WR_DRAIN: begin
            MAXIGP0_O_W__RDY = 1'b1;
            if (MAXIGP0_O_W__ENA && MAXIGP0_O_W_last)
               wr_next = WR_ERR;
         end
         WR_ERR: begin
            MAXIGP0_I_B__ENA = 1'b1;
            MAXIGP0_I_B_resp = 2'b11;
            if (MAXIGP0_I_B__RDY)
               wr_next = WR_IDLE;
         end
         default: wr_next = WR_IDLE;
      endcase
   end

endmodule

// File: tb/tb_maxigp_port_splitter.sv
// Testbench for maxigp_port_splitter (NPORT=4, 32-bit data, 12-bit ids).
// Read transactions come from a vector table; write, backpressure,
// concurrency and reset cases are hand-written sequences.
module tb_maxigp_port_splitter;

   logic         CLK = 1'b0;
   logic         nRST = 1'b0;

   logic         ar_ena = 0, ar_rdy;
   logic [31:0]  ar_addr = 0;
   logic [11:0]  ar_id = 0;
   logic [3:0]   ar_len = 0;
   logic         aw_ena = 0, aw_rdy;
   logic [31:0]  aw_addr = 0;
   logic [11:0]  aw_id = 0;
   logic [3:0]   aw_len = 0;
   logic         w_ena = 0, w_rdy;
   logic [31:0]  w_data = 0;
   logic [11:0]  w_id = 0;
   logic         w_last = 0;
   logic         r_ena, r_rdy = 0;
   logic [31:0]  r_data;
   logic [11:0]  r_id;
   logic         r_last;
   logic [1:0]   r_resp;
   logic         b_ena, b_rdy = 0;
   logic [11:0]  b_id;
   logic [1:0]   b_resp;

   logic [3:0]   p_ar_ena, p_ar_rdy = 0;
   logic [127:0] p_ar_addr;
   logic [15:0]  p_ar_len;
   logic [3:0]   p_aw_ena, p_aw_rdy = 0;
   logic [127:0] p_aw_addr;
   logic [15:0]  p_aw_len;
   logic [3:0]   p_w_ena, p_w_rdy = 0;
   logic [127:0] p_w_data;
   logic [3:0]   p_w_last;
   logic [3:0]   p_r_ena = 0, p_r_rdy;
   logic [127:0] p_r_data = 0;
   logic [3:0]   p_r_last = 0;
   logic [7:0]   p_r_resp = 0;
   logic [3:0]   p_b_ena = 0, p_b_rdy;
   logic [7:0]   p_b_resp = 0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] addr;
      logic [11:0] id;
      logic [3:0]  len;
      int          port;
      logic [31:0] rdata;
   } rd_vec_t;

   rd_vec_t vecs[6];

   always #5 CLK = ~CLK;

   maxigp_port_splitter #(.NPORT(4), .DATA_WIDTH(32), .ID_WIDTH(12), .SEL_LSB(12)) dut (
      .CLK(CLK), .nRST(nRST),
      .MAXIGP0_O_AR__ENA(ar_ena), .MAXIGP0_O_AR__RDY(ar_rdy),
      .MAXIGP0_O_AR_addr(ar_addr), .MAXIGP0_O_AR_id(ar_id), .MAXIGP0_O_AR_len(ar_len),
      .MAXIGP0_O_AW__ENA(aw_ena), .MAXIGP0_O_AW__RDY(aw_rdy),
      .MAXIGP0_O_AW_addr(aw_addr), .MAXIGP0_O_AW_id(aw_id), .MAXIGP0_O_AW_len(aw_len),
      .MAXIGP0_O_W__ENA(w_ena), .MAXIGP0_O_W__RDY(w_rdy),
      .MAXIGP0_O_W_data(w_data), .MAXIGP0_O_W_id(w_id), .MAXIGP0_O_W_last(w_last),
      .MAXIGP0_I_R__ENA(r_ena), .MAXIGP0_I_R__RDY(r_rdy),
      .MAXIGP0_I_R_data(r_data), .MAXIGP0_I_R_id(r_id), .MAXIGP0_I_R_last(r_last),
      .MAXIGP0_I_R_resp(r_resp),
      .MAXIGP0_I_B__ENA(b_ena), .MAXIGP0_I_B__RDY(b_rdy),
      .MAXIGP0_I_B_id(b_id), .MAXIGP0_I_B_resp(b_resp),
      .port_AR__ENA(p_ar_ena), .port_AR__RDY(p_ar_rdy), .port_AR_addr(p_ar_addr), .port_AR_len(p_ar_len),
      .port_AW__ENA(p_aw_ena), .port_AW__RDY(p_aw_rdy), .port_AW_addr(p_aw_addr), .port_AW_len(p_aw_len),
      .port_W__ENA(p_w_ena), .port_W__RDY(p_w_rdy), .port_W_data(p_w_data), .port_W_last(p_w_last),
      .port_R__ENA(p_r_ena), .port_R__RDY(p_r_rdy), .port_R_data(p_r_data),
      .port_R_last(p_r_last), .port_R_resp(p_r_resp),
      .port_B__ENA(p_b_ena), .port_B__RDY(p_b_rdy), .port_B_resp(p_b_resp)
   );

   // Compare one value and report mismatches.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next falling edge; inputs are driven and
   // outputs sampled there, well away from the rising edge.
   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   // One complete read transaction from the vector table.
   task automatic applyStimulus(input rd_vec_t v);
      logic [3:0] exp_ena;
      exp_ena = (v.port >= 0) ? 4'(1 << v.port) : 4'b0000;
      ar_ena = 1; ar_addr = v.addr; ar_id = v.id; ar_len = v.len;
      #1;
      checkOutput("rd ar_rdy idle", 64'(ar_rdy), 64'd1);
      tick();
      ar_ena = 0;
      #1;
      checkOutput("rd port_AR ena", 64'(p_ar_ena), 64'(exp_ena));
      checkOutput("rd ar_rdy busy", 64'(ar_rdy), 64'd0);
      if (v.port >= 0) begin
         checkOutput("rd port_AR addr", 64'(p_ar_addr[v.port*32 +: 32]), 64'(v.addr));
         checkOutput("rd port_AR len", 64'(p_ar_len[v.port*4 +: 4]), 64'(v.len));
         p_ar_rdy = exp_ena;
         tick();
         p_ar_rdy = 0;
         for (int k = 0; k <= int'(v.len); k++) begin
            p_r_data = {4{32'hBAD0BAD0}};
            p_r_resp = 8'hAA;
            p_r_last = 4'b0000;
            p_r_ena  = exp_ena;
            p_r_data[v.port*32 +: 32] = v.rdata + 32'(k);
            p_r_last[v.port] = (k == int'(v.len));
            p_r_resp[v.port*2 +: 2] = 2'b00;
            r_rdy = 1;
            #1;
            checkOutput("rd r_ena", 64'(r_ena), 64'd1);
            checkOutput("rd r_data", 64'(r_data), 64'(v.rdata + 32'(k)));
            checkOutput("rd r_id", 64'(r_id), 64'(v.id));
            checkOutput("rd r_last", 64'(r_last), 64'(k == int'(v.len)));
            checkOutput("rd r_resp", 64'(r_resp), 64'd0);
            checkOutput("rd port_R rdy", 64'(p_r_rdy), 64'(exp_ena));
            tick();
         end
      end else begin
         r_rdy = 1;
         for (int k = 0; k <= int'(v.len); k++) begin
            #1;
            checkOutput("err r_ena", 64'(r_ena), 64'd1);
            checkOutput("err r_data", 64'(r_data), 64'd0);
            checkOutput("err r_resp", 64'(r_resp), 64'd3);
            checkOutput("err r_id", 64'(r_id), 64'(v.id));
            checkOutput("err r_last", 64'(r_last), 64'(k == int'(v.len)));
            checkOutput("err port_AR ena", 64'(p_ar_ena), 64'd0);
            tick();
         end
      end
      p_r_ena = 0; p_r_last = 0; r_rdy = 0;
      #1;
      checkOutput("rd r_ena after last", 64'(r_ena), 64'd0);
      checkOutput("rd ar_rdy after last", 64'(ar_rdy), 64'd1);
   endtask

   initial begin
      int k;
      int cyc;

      vecs[0] = '{addr: 32'h0000_2010, id: 12'h05A, len: 4'd0,  port: 2,  rdata: 32'hDEAD_BEEF};
      vecs[1] = '{addr: 32'h0000_0004, id: 12'h001, len: 4'd0,  port: 0,  rdata: 32'h1111_1111};
      vecs[2] = '{addr: 32'h0000_3FFC, id: 12'hABC, len: 4'd2,  port: 3,  rdata: 32'h3333_0000};
      vecs[3] = '{addr: 32'h1234_1000, id: 12'h7E7, len: 4'd0,  port: 1,  rdata: 32'h2222_2222};
      vecs[4] = '{addr: 32'h0000_4000, id: 12'h044, len: 4'd0,  port: -1, rdata: 32'h0};
      vecs[5] = '{addr: 32'h0000_F000, id: 12'h0F0, len: 4'd15, port: -1, rdata: 32'h0};

      // Reset state: everything quiet, address readies low while in reset.
      #3;
      checkOutput("reset ar_rdy", 64'(ar_rdy), 64'd0);
      checkOutput("reset aw_rdy", 64'(aw_rdy), 64'd0);
      checkOutput("reset port enas", 64'({p_ar_ena, p_aw_ena, p_w_ena}), 64'd0);
      checkOutput("reset r/b ena", 64'({r_ena, b_ena}), 64'd0);
      checkOutput("reset w_rdy", 64'(w_rdy), 64'd0);
      repeat (2) @(negedge CLK);
      nRST = 1;
      #1;
      checkOutput("release ar_rdy same cycle", 64'(ar_rdy), 64'd0);
      tick();
      checkOutput("release ar_rdy", 64'(ar_rdy), 64'd1);
      checkOutput("release aw_rdy", 64'(aw_rdy), 64'd1);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
         tick();
      end

      // Write burst to port 1; an early W beat is held off until WR_DATA.
      aw_ena = 1; aw_addr = 32'h0000_1000; aw_id = 12'h077; aw_len = 4'd3;
      w_ena = 1; w_data = 32'hA0; w_last = 0; w_id = 12'hFFF;
      #1;
      checkOutput("wr w_rdy before aw", 64'(w_rdy), 64'd0);
      tick();
      aw_ena = 0;
      #1;
      checkOutput("wr port_AW ena", 64'(p_aw_ena), 64'b0010);
      checkOutput("wr port_AW addr", 64'(p_aw_addr[63:32]), 64'h1000);
      checkOutput("wr port_AW len", 64'(p_aw_len[7:4]), 64'd3);
      checkOutput("wr w_rdy in issue", 64'(w_rdy), 64'd0);
      checkOutput("wr port_W ena in issue", 64'(p_w_ena), 64'd0);
      p_aw_rdy = 4'b0010;
      tick();
      p_aw_rdy = 0;
      for (int b = 0; b < 4; b++) begin
         w_data = 32'hA0 + 32'(b); w_last = (b == 3); p_w_rdy = 4'b0010;
         #1;
         checkOutput("wr port_W ena", 64'(p_w_ena), 64'b0010);
         checkOutput("wr w_rdy", 64'(w_rdy), 64'd1);
         checkOutput("wr port_W data", 64'(p_w_data[63:32]), 64'(32'hA0 + 32'(b)));
         checkOutput("wr port_W last", 64'(p_w_last[1]), 64'(b == 3));
         tick();
      end
      w_ena = 0; w_last = 0; p_w_rdy = 0;
      p_b_ena = 4'b0010; p_b_resp = 8'b11_11_00_11; b_rdy = 1;
      #1;
      checkOutput("wr b_ena", 64'(b_ena), 64'd1);
      checkOutput("wr b_id", 64'(b_id), 64'h077);
      checkOutput("wr b_resp", 64'(b_resp), 64'd0);
      checkOutput("wr port_B rdy", 64'(p_b_rdy), 64'b0010);
      tick();
      p_b_ena = 0; b_rdy = 0;
      #1;
      checkOutput("wr aw_rdy after b", 64'(aw_rdy), 64'd1);
      tick();

      // Write decode miss: two W beats drained, then DECERR held until taken.
      aw_ena = 1; aw_addr = 32'h0000_F000; aw_id = 12'h03C; aw_len = 4'd1;
      tick();
      aw_ena = 0; w_ena = 1; w_data = 32'h55; w_last = 0;
      #1;
      checkOutput("drain port_AW ena", 64'(p_aw_ena), 64'd0);
      checkOutput("drain w_rdy", 64'(w_rdy), 64'd1);
      checkOutput("drain port_W ena", 64'(p_w_ena), 64'd0);
      tick();
      w_last = 1;
      #1;
      checkOutput("drain w_rdy last", 64'(w_rdy), 64'd1);
      checkOutput("drain b_ena early", 64'(b_ena), 64'd0);
      tick();
      w_ena = 0; w_last = 0;
      #1;
      checkOutput("werr b_ena", 64'(b_ena), 64'd1);
      checkOutput("werr b_resp", 64'(b_resp), 64'd3);
      checkOutput("werr b_id", 64'(b_id), 64'h03C);
      checkOutput("werr w_rdy", 64'(w_rdy), 64'd0);
      tick();
      checkOutput("werr b_ena held", 64'(b_ena), 64'd1);
      checkOutput("werr aw_rdy held", 64'(aw_rdy), 64'd0);
      b_rdy = 1;
      tick();
      b_rdy = 0;
      #1;
      checkOutput("werr b_ena done", 64'(b_ena), 64'd0);
      checkOutput("werr aw_rdy", 64'(aw_rdy), 64'd1);
      tick();

      // Backpressure: upstream R ready low for 5 cycles in a 4-beat burst.
      ar_ena = 1; ar_addr = 32'h0000_2000; ar_id = 12'h00B; ar_len = 4'd3;
      tick();
      ar_ena = 0; p_ar_rdy = 4'b0100;
      tick();
      p_ar_rdy = 0;
      k = 0;
      cyc = 0;
      while (k < 4 && cyc < 40) begin
         p_r_ena = 4'b0100;
         p_r_data[95:64] = 32'hC0DE_0000 + 32'(k);
         p_r_last[2] = (k == 3);
         p_r_resp = 0;
         r_rdy = !(cyc >= 2 && cyc < 7);
         #1;
         checkOutput("bp port_R rdy", 64'(p_r_rdy), 64'({1'b0, r_rdy, 2'b00}));
         checkOutput("bp r_data", 64'(r_data), 64'(32'hC0DE_0000 + 32'(k)));
         checkOutput("bp r_ena", 64'(r_ena), 64'd1);
         if (r_rdy) begin
            checkOutput("bp r_last", 64'(r_last), 64'(k == 3));
            k++;
         end
         cyc++;
         tick();
      end
      checkOutput("bp beat count", 64'(k), 64'd4);
      checkOutput("bp cycle count", 64'(cyc), 64'd9);
      p_r_ena = 0; p_r_last = 0; r_rdy = 0;
      #1;
      checkOutput("bp ar_rdy after", 64'(ar_rdy), 64'd1);
      tick();

      // Concurrent read to port 0 and write to port 3.
      ar_ena = 1; ar_addr = 32'h0000_0100; ar_id = 12'h011; ar_len = 0;
      aw_ena = 1; aw_addr = 32'h0000_3000; aw_id = 12'h022; aw_len = 0;
      tick();
      ar_ena = 0; aw_ena = 0;
      #1;
      checkOutput("cc port_AR ena", 64'(p_ar_ena), 64'b0001);
      checkOutput("cc port_AW ena", 64'(p_aw_ena), 64'b1000);
      p_ar_rdy = 4'b0001; p_aw_rdy = 4'b1000;
      tick();
      p_ar_rdy = 0; p_aw_rdy = 0;
      w_ena = 1; w_data = 32'h7777; w_last = 1; p_w_rdy = 4'b1000;
      #1;
      checkOutput("cc port_W ena", 64'(p_w_ena), 64'b1000);
      checkOutput("cc ar_rdy w", 64'(ar_rdy), 64'd0);
      checkOutput("cc r_ena idle", 64'(r_ena), 64'd0);
      tick();
      w_ena = 0; w_last = 0; p_w_rdy = 0;
      p_b_ena = 4'b1000; p_b_resp = 8'b00_11_11_11; b_rdy = 1;
      #1;
      checkOutput("cc b_id", 64'(b_id), 64'h022);
      checkOutput("cc b_resp", 64'(b_resp), 64'd0);
      checkOutput("cc ar_rdy b", 64'(ar_rdy), 64'd0);
      tick();
      p_b_ena = 0; b_rdy = 0;
      p_r_ena = 4'b0001; p_r_data[31:0] = 32'h0F0F_0F0F; p_r_last = 4'b0001; p_r_resp = 0; r_rdy = 1;
      #1;
      checkOutput("cc r_id", 64'(r_id), 64'h011);
      checkOutput("cc r_data", 64'(r_data), 64'h0F0F_0F0F);
      checkOutput("cc ar_rdy at last", 64'(ar_rdy), 64'd0);
      tick();
      p_r_ena = 0; p_r_last = 0; r_rdy = 0;
      #1;
      checkOutput("cc ar_rdy done", 64'(ar_rdy), 64'd1);
      checkOutput("cc aw_rdy done", 64'(aw_rdy), 64'd1);
      tick();

      // Asynchronous reset in WR_DATA, then a fresh write to port 2.
      aw_ena = 1; aw_addr = 32'h0000_1000; aw_id = 12'h0AA; aw_len = 4'd1;
      tick();
      aw_ena = 0; p_aw_rdy = 4'b0010;
      tick();
      p_aw_rdy = 0; w_ena = 1; w_data = 32'h1; w_last = 0; p_w_rdy = 4'b0010;
      #1;
      checkOutput("rst port_W ena before", 64'(p_w_ena), 64'b0010);
      #1;
      nRST = 0;
      #1;
      checkOutput("rst port enas", 64'({p_ar_ena, p_aw_ena, p_w_ena}), 64'd0);
      checkOutput("rst r/b ena", 64'({r_ena, b_ena}), 64'd0);
      checkOutput("rst w_rdy", 64'(w_rdy), 64'd0);
      w_ena = 0; p_w_rdy = 0;
      tick();
      nRST = 1;
      tick();
      checkOutput("rst aw_rdy after", 64'(aw_rdy), 64'd1);
      aw_ena = 1; aw_addr = 32'h0000_2000; aw_id = 12'h0BB; aw_len = 0;
      tick();
      aw_ena = 0;
      #1;
      checkOutput("fresh port_AW ena", 64'(p_aw_ena), 64'b0100);
      p_aw_rdy = 4'b0100;
      tick();
      p_aw_rdy = 0; w_ena = 1; w_data = 32'h9999; w_last = 1; p_w_rdy = 4'b0100;
      #1;
      checkOutput("fresh port_W data", 64'(p_w_data[95:64]), 64'h9999);
      checkOutput("fresh port_W ena", 64'(p_w_ena), 64'b0100);
      tick();
      w_ena = 0; w_last = 0; p_w_rdy = 0;
      p_b_ena = 4'b0100; p_b_resp = 8'b11_00_11_11; b_rdy = 1;
      #1;
      checkOutput("fresh b_id", 64'(b_id), 64'h0BB);
      checkOutput("fresh b_resp", 64'(b_resp), 64'd0);
      tick();
      p_b_ena = 0; b_rdy = 0;
      #1;
      checkOutput("fresh aw_rdy", 64'(aw_rdy), 64'd1);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
